// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg7_pkg;

  localparam int DIV_DEF   = 50000;
  localparam int GUARD_DEF = 4;
  localparam int NDIG      = 4;
  localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

  // A digit is blanked if it is a leading zero of an unflagged value; digit 0 always shows.
  function automatic logic digit_blank(input logic [15:0] val, input logic [1:0] idx,
                                       input logic blz, input logic st_err, input logic st_good);
    return blz && !st_err && !st_good && (idx != 2'd0) && ((val >> {idx, 2'b00}) == 16'h0000);
  endfunction

  function automatic logic [NDIG-1:0] an_select(input logic [1:0] idx);
    return ~(NDIG'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_prescale.sv
// Free-running slot prescaler; tick marks the last cycle of every DIV-cycle slot.
module seg7_prescale #(
  parameter int DIV = seg7_pkg::DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit display scanner: latches a hex value plus status and time-multiplexes the anodes.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [15:0]     value,
  input  logic            err_in,
  input  logic            good_in,
  input  logic            blank_lz,
  output logic [3:0]      digit,
  output logic [1:0]      sel,
  output logic            err,
  output logic            good,
  output logic [NDIG-1:0] an,
  output logic            frame_done
);

  logic        tick;
  logic [15:0] value_q, value_n;
  logic        blz_q, blz_n;
  logic        err_n, good_n;
  logic [1:0]  sel_n;
  logic [15:0] gcnt, gcnt_n;
  logic        blank_n;

  seg7_prescale #(.DIV(DIV)) u_prescale (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Outputs are computed from next-state values so a load landing on a tick
  // is already visible in the first cycle of the new slot.
  always_comb begin
    value_n = load ? value    : value_q;
    blz_n   = load ? blank_lz : blz_q;
    err_n   = load ? err_in   : err;
    good_n  = load ? (good_in & ~err_in) : good;
    sel_n   = tick ? sel + 2'd1 : sel;
    gcnt_n  = gcnt;
    if (tick) begin
      gcnt_n = '0;
    end else if (gcnt < 16'(GUARD)) begin
      gcnt_n = gcnt + 16'd1;
    end
    blank_n = digit_blank(value_n, sel_n, blz_n, err_n, good_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q    <= '0;
      blz_q      <= 1'b0;
      err        <= 1'b0;
      good       <= 1'b0;
      sel        <= '0;
      gcnt       <= '0;
      digit      <= '0;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      value_q    <= value_n;
      blz_q      <= blz_n;
      err        <= err_n;
      good       <= good_n;
      sel        <= sel_n;
      gcnt       <= gcnt_n;
      digit      <= value_n[{sel_n, 2'b00} +: 4];
      an         <= ((gcnt_n < 16'(GUARD)) || blank_n) ? AN_OFF : an_select(sel_n);
      frame_done <= tick && (sel == 2'd3);
    end
  end

endmodule
